spi_responder: RTL

SPI responder (slave) for the SPI bus our master drives: mode 0 (CPOL=0, CPHA=0), MSB first, active-low chip select. All pin inputs are oversampled in the system clock domain. Each received byte is presented on a one-cycle-valid output. Transmit bytes are supplied through a one-entry holding buffer with a ready/load handshake. The block sits behind the board SPI pins, opposite the master FSM, and gives a processor-side peripheral a byte-stream interface.

---
 rtl/spi_pkg.sv | 6 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared word width, idle byte and state type for the SPI responder
package spi_pkg;
  localparam int SPI_DATA_W = 8;
  localparam logic [SPI_DATA_W-1:0] SPI_IDLE_BYTE = 8'hFF;
  typedef enum logic {IDLE, SHIFT} spi_resp_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with registered previous value for edge events
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;
endmodule

// File: rtl/spi_responder.sv
// spi_responder: mode-0 SPI slave with oversampled pins, byte rx output and one-entry tx buffer
module spi_responder
  import spi_pkg::*;
#(
  parameter int               DATA_W    = SPI_DATA_W,
  parameter logic [DATA_W-1:0] IDLE_BYTE = SPI_IDLE_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic unused;
  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .din(sck), .sync(sck_sync), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .din(cs), .sync(cs_sync), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(mosi), .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall));
  assign unused = ^{sck_sync, cs_sync, mosi_rise, mosi_fall};
  spi_resp_state_t   state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              tx_ready_q, tx_ready_d;
  logic              reload, last_bit;
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    buf_d      = buf_q;
    tx_ready_d = tx_ready_q;
    reload     = 1'b0;
    last_bit   = bit_cnt_q == CW'(DATA_W - 1);
    if (tx_load && tx_ready_q) begin
      buf_d      = tx_data;
      tx_ready_d = 1'b0;
    end
    if (state_q == IDLE) begin
      if (cs_fall) begin
        state_d   = SHIFT;
        bit_cnt_d = '0;
        reload    = 1'b1;
      end
    end else if (cs_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else begin
      if (sck_rise) begin
        rx_shift_d = {rx_shift_q[DATA_W-3:0], mosi_sync};
        bit_cnt_d  = last_bit ? '0 : bit_cnt_q + 1'b1;
        rx_data_d  = last_bit ? {rx_shift_q, mosi_sync} : rx_data_q;
        rx_valid_d = last_bit;
      end
      if (sck_fall) begin
        reload     = bit_cnt_q == '0;
        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
      end
    end
    // a load arriving with a consume on an empty buffer stays buffered for the next byte
    if (reload) begin
      tx_shift_d = tx_ready_q ? IDLE_BYTE : buf_q;
      tx_ready_d = tx_ready_q ? tx_ready_d : 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= IDLE_BYTE;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      buf_q      <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      buf_q      <= buf_d;
      tx_ready_q <= tx_ready_d;
    end
  end
  assign miso     = (state_q == SHIFT) ? tx_shift_q[DATA_W-1] : 1'b1;
  assign busy     = state_q == SHIFT;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
endmodule
